sram_bank: RTL and testbench



---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_nibble_lane.sv | 37 +++
 rtl/sram_bank.sv | 155 +++++++++++++++
 tb/tb_sram_bank.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the ganged-nibble SRAM bank.
package sram_pkg;

  localparam int unsigned NIBBLE_WIDTH = 4;

  // Controller states: IDLE accepts work, ACCESS models access time,
  // DONE pulses ack, CLEAR sweeps zeros through the whole array.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  // Word width of a bank built from the given number of nibble lanes.
  function automatic int unsigned data_width(input int unsigned lanes);
    return lanes * NIBBLE_WIDTH;
  endfunction

endpackage

// File: rtl/sram_nibble_lane.sv
// One 4-bit-wide storage lane (a clocked 2114 when ADDR_WIDTH=10).
// Ports:
//   clk, reset_n : clock, async active-low reset (read register only)
//   we           : synchronous write of wdata at addr
//   re           : synchronous read of addr into rdata
//   addr, wdata  : word address and nibble write data
//   rdata        : registered read nibble, holds between reads
module sram_nibble_lane
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [NIBBLE_WIDTH-1:0] wdata,
  output logic [NIBBLE_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [NIBBLE_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the bank's clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_bank.sv
// Word-wide SRAM bank built from LANES nibble lanes, with a req/ack
// handshake, WAIT_STATES cycles of emulated access time, per-nibble write
// enables and a hardware zero-sweep (on reset and/or on clear_req).
// Ports:
//   clk, reset_n : clock, async active-low reset
//   req, we      : access request and direction, sampled in IDLE only
//   addr, wdata  : word address and write data, captured with req
//   lane_en      : per-nibble write enable, bit i covers wdata[4i+3:4i]
//   clear_req    : request a full-array zero sweep
//   rdata        : registered read data, changes only on read completion
//   ack          : one-cycle completion pulse for each access
//   busy         : high whenever the controller is not in IDLE
module sram_bank
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned LANES          = 8,
  parameter int unsigned WAIT_STATES    = 2,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req,
  input  logic                          we,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [data_width(LANES)-1:0]  wdata,
  input  logic [LANES-1:0]              lane_en,
  input  logic                          clear_req,
  output logic [data_width(LANES)-1:0]  rdata,
  output logic                          ack,
  output logic                          busy
);

  localparam int unsigned DATA_WIDTH = data_width(LANES);
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned CLR_W      = ADDR_WIDTH + 1;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CLR_W-1:0]        clr_q, clr_d;
  logic                    pend_q, pend_d;
  logic                    cap_en;
  logic                    cap_we;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic [LANES-1:0]        cap_lane_en;

  logic [LANES-1:0]        lane_we;
  logic                    lane_re;
  logic [ADDR_WIDTH-1:0]   lane_addr;
  logic [DATA_WIDTH-1:0]   lane_wdata;

  // State, counters, captured request and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q       <= '0;
      clr_q       <= '0;
      pend_q      <= 1'b0;
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      cap_lane_en <= '0;
      ack         <= 1'b0;
      busy        <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      pend_q  <= pend_d;
      if (cap_en) begin
        cap_we      <= we;
        cap_addr    <= addr;
        cap_wdata   <= wdata;
        cap_lane_en <= lane_en;
      end
      ack  <= (state_d == ST_DONE);
      busy <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic and lane control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_d      = clr_q;
    pend_d     = pend_q;
    cap_en     = 1'b0;
    lane_we    = '0;
    lane_re    = 1'b0;
    lane_addr  = cap_addr;
    lane_wdata = cap_wdata;
    case (state_q)
      ST_IDLE: begin
        // A clear wins over a simultaneous request; the request is dropped.
        if (clear_req) begin
          state_d = ST_CLEAR;
          clr_d   = '0;
        end else if (req) begin
          cap_en  = 1'b1;
          cnt_d   = CNT_W'(WAIT_STATES - 1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (clear_req) pend_d = 1'b1;
        // The array is touched on a single edge, so an aborted access never
        // leaves a partial write behind.
        if (cnt_q == '0) begin
          if (cap_we) lane_we = cap_lane_en;
          else        lane_re = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (pend_q || clear_req) begin
          state_d = ST_CLEAR;
          pend_d  = 1'b0;
          clr_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        lane_we    = '1;
        lane_addr  = clr_q[ADDR_WIDTH-1:0];
        lane_wdata = '0;
        if (clr_q == CLR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + CLR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane i stores wdata[4i+3:4i]; address and read strobe are shared.
  sram_nibble_lane #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) lane [LANES-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (lane_we),
    .re      (lane_re),
    .addr    (lane_addr),
    .wdata   (lane_wdata),
    .rdata   (rdata)
  );

endmodule

// File: tb/tb_sram_bank.sv
// Self-checking bench for sram_bank: three builds (defaults; WAIT_STATES=5
// without clear-on-reset; WAIT_STATES=1), directed cases with literal
// expectations and a randomized run on the default build against a
// timeline model of the handshake and a word-level memory model.
module tb_sram_bank;

  localparam int DEPTH = 1024;
  localparam int W0    = 2;

  logic        clk;
  logic        rst_x   [3];
  logic        req_x   [3];
  logic        we_x    [3];
  logic        clr_x   [3];
  logic [9:0]  addr_x  [3];
  logic [31:0] wdata_x [3];
  logic [7:0]  len_x   [3];
  logic [31:0] rdata_x [3];
  logic        ack_x   [3];
  logic        busy_x  [3];

  int checks = 0;
  int passed = 0;

  sram_bank #(.ADDR_WIDTH(10), .LANES(8), .WAIT_STATES(2), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .reset_n(rst_x[0]), .req(req_x[0]), .we(we_x[0]), .addr(addr_x[0]),
    .wdata(wdata_x[0]), .lane_en(len_x[0]), .clear_req(clr_x[0]),
    .rdata(rdata_x[0]), .ack(ack_x[0]), .busy(busy_x[0]));

  sram_bank #(.ADDR_WIDTH(10), .LANES(8), .WAIT_STATES(5), .CLEAR_ON_RESET(0)) dut1 (
    .clk(clk), .reset_n(rst_x[1]), .req(req_x[1]), .we(we_x[1]), .addr(addr_x[1]),
    .wdata(wdata_x[1]), .lane_en(len_x[1]), .clear_req(clr_x[1]),
    .rdata(rdata_x[1]), .ack(ack_x[1]), .busy(busy_x[1]));

  sram_bank #(.ADDR_WIDTH(10), .LANES(8), .WAIT_STATES(1), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .reset_n(rst_x[2]), .req(req_x[2]), .we(we_x[2]), .addr(addr_x[2]),
    .wdata(wdata_x[2]), .lane_en(len_x[2]), .clear_req(clr_x[2]),
    .rdata(rdata_x[2]), .ack(ack_x[2]), .busy(busy_x[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- model of dut0 (edge-indexed timeline) ----------------
  int          k        = 0;
  int          idle_at  = DEPTH + 1;
  int          ack_edge = -1;
  int          rd_edge  = -1;
  int          acc_e    = 0;
  bit          acc_valid = 0;
  bit          clr_sched = 0;
  logic [31:0] rd_val   = '0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] m [DEPTH];
  bit          cmp_on = 0;

  initial for (int i = 0; i < DEPTH; i++) m[i] = '0;

  always @(posedge clk) begin
    if (rst_x[0] === 1'b1) begin
      k++;
      if (k == rd_edge) exp_rdata = rd_val;
      if (k >= idle_at) begin
        acc_valid = 0;
        if (clr_x[0]) begin
          idle_at = k + DEPTH + 1;
          for (int i = 0; i < DEPTH; i++) m[i] = '0;
        end else if (req_x[0]) begin
          acc_e = k; acc_valid = 1; clr_sched = 0;
          idle_at  = k + W0 + 2;
          ack_edge = k + W0;
          if (we_x[0]) begin
            for (int l = 0; l < 8; l++)
              if (len_x[0][l]) m[addr_x[0]][4*l +: 4] = wdata_x[0][4*l +: 4];
          end else begin
            rd_val  = m[addr_x[0]];
            rd_edge = k + W0;
          end
        end
      end else if (acc_valid && !clr_sched && k > acc_e && k <= acc_e + W0 + 1 && clr_x[0]) begin
        clr_sched = 1;
        idle_at   = acc_e + W0 + 1 + DEPTH + 1;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
      end
    end
  end

  // Per-cycle comparison of dut0 against the model.
  always @(negedge clk) begin
    if (cmp_on && rst_x[0] === 1'b1) begin
      check("cyc_ack",   32'(ack_x[0]),  32'(k == ack_edge));
      check("cyc_busy",  32'(busy_x[0]), 32'(k < idle_at - 1));
      check("cyc_rdata", rdata_x[0],     exp_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic access(input int s, input logic w, input logic [9:0] a,
                        input logic [31:0] d, input logic [7:0] le,
                        output logic [31:0] rd, output int lat);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (busy_x[s] !== 1'b0 && guard < 3000) begin
      @(posedge clk); #1; guard++;
    end
    check("idle_wait_timeout", 32'(guard >= 3000), 32'd0);
    req_x[s] = 1'b1; we_x[s] = w; addr_x[s] = a; wdata_x[s] = d; len_x[s] = le;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) req_x[s] = 1'b0;
    end while (ack_x[s] !== 1'b1 && lat < 100);
    check("ack_timeout", 32'(lat >= 100), 32'd0);
    rd = rdata_x[s];
  endtask

  task automatic count_busy(input int s, output int n, output int acks);
    n = 0; acks = 0;
    forever begin
      @(negedge clk);
      if (ack_x[s] === 1'b1) acks++;
      if (busy_x[s] !== 1'b1 || n >= 3000) break;
      n++;
    end
  endtask

  logic [31:0] rd;
  int lat, n, acks;

  initial begin
    for (int s = 0; s < 3; s++) begin
      rst_x[s] = 1'b0; req_x[s] = 1'b0; we_x[s] = 1'b0; clr_x[s] = 1'b0;
      addr_x[s] = '0; wdata_x[s] = '0; len_x[s] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", rdata_x[0], 32'h0);
    check("rst_ack",   32'(ack_x[0]), 32'd0);
    check("rst_busy_cor1", 32'(busy_x[0]), 32'd1);
    check("rst_busy_cor0", 32'(busy_x[1]), 32'd0);
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) rst_x[s] = 1'b1;
    cmp_on = 1;

    // Reset sweep length and first read.
    count_busy(0, n, acks);
    check("t1_busy_cycles", 32'(n), 32'd1024);
    check("t1_sweep_acks", 32'(acks), 32'd0);
    access(0, 1'b0, 10'h3FF, '0, '0, rd, lat);
    check("t1_read_3ff", rd, 32'h0);
    check("t1_latency", 32'(lat), 32'd3);

    // Basic write/read.
    access(0, 1'b1, 10'h000, 32'hDEADBEEF, 8'hFF, rd, lat);
    access(0, 1'b1, 10'h001, 32'h12345678, 8'hFF, rd, lat);
    access(0, 1'b0, 10'h000, '0, '0, rd, lat);
    check("t2_read_000", rd, 32'hDEADBEEF);
    access(0, 1'b0, 10'h001, '0, '0, rd, lat);
    check("t2_read_001", rd, 32'h12345678);
    access(0, 1'b1, 10'h002, 32'h0BADF00D, 8'hFF, rd, lat);
    check("t2_write_keeps_rdata", rd, 32'h12345678);
    access(0, 1'b0, 10'h000, '0, '0, rd, lat);
    check("t2_reread_000", rd, 32'hDEADBEEF);

    // Lane enables.
    access(0, 1'b1, 10'h100, 32'hFFFFFFFF, 8'hFF, rd, lat);
    access(0, 1'b1, 10'h100, 32'h00000000, 8'h0F, rd, lat);
    access(0, 1'b0, 10'h100, '0, '0, rd, lat);
    check("t3_lane_merge", rd, 32'hFFFF0000);

    // Simultaneous req + clear_req: clear wins, no ack.
    access(0, 1'b1, 10'h050, 32'h12345678, 8'hFF, rd, lat);
    @(posedge clk); #1;
    req_x[0] = 1'b1; we_x[0] = 1'b0; addr_x[0] = 10'h050; clr_x[0] = 1'b1;
    @(posedge clk); #1;
    req_x[0] = 1'b0; clr_x[0] = 1'b0;
    count_busy(0, n, acks);
    check("t4_clear_busy", 32'(n), 32'd1024);
    check("t4_clear_no_ack", 32'(acks), 32'd0);
    access(0, 1'b0, 10'h050, '0, '0, rd, lat);
    check("t4_cleared_word", rd, 32'h0);

    // clear_req during a read: read completes, then the sweep.
    access(0, 1'b1, 10'h3FD, 32'h0000000D, 8'hFF, rd, lat);
    @(posedge clk); #1;
    req_x[0] = 1'b1; we_x[0] = 1'b0; addr_x[0] = 10'h3FD;
    @(posedge clk); #1;
    req_x[0] = 1'b0; clr_x[0] = 1'b1;
    @(posedge clk); #1;
    clr_x[0] = 1'b0;
    @(posedge clk); #1;
    check("t4_inflight_ack", 32'(ack_x[0]), 32'd1);
    check("t4_inflight_rdata", rdata_x[0], 32'h0000000D);
    count_busy(0, n, acks);
    check("t4_pending_sweep", 32'(n), 32'd1025);
    access(0, 1'b0, 10'h3FD, '0, '0, rd, lat);
    check("t4_after_sweep", rd, 32'h0);

    // Back-to-back with req held: one access per WAIT_STATES+2 cycles.
    @(posedge clk); #1;
    req_x[0] = 1'b1; we_x[0] = 1'b0; addr_x[0] = 10'h001;
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); if (ack_x[0] === 1'b1) acks++;
    end
    @(posedge clk); #1; req_x[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (ack_x[0] === 1'b1) acks++;
    end
    check("t5_held_req_acks", 32'(acks), 32'd4);

    // Other builds: latency.
    access(2, 1'b1, 10'h010, 32'hCAFEF00D, 8'hFF, rd, lat);
    check("t5_ws1_latency", 32'(lat), 32'd2);
    access(2, 1'b0, 10'h010, '0, '0, rd, lat);
    check("t5_ws1_read", rd, 32'hCAFEF00D);
    access(1, 1'b1, 10'h200, 32'h55555555, 8'hFF, rd, lat);
    check("t5_ws5_latency", 32'(lat), 32'd6);
    access(1, 1'b0, 10'h200, '0, '0, rd, lat);
    check("t6_preload", rd, 32'h55555555);

    // Reset in the middle of a write access aborts it.
    @(posedge clk); #1;
    req_x[1] = 1'b1; we_x[1] = 1'b1; addr_x[1] = 10'h200; wdata_x[1] = 32'hAAAAAAAA; len_x[1] = 8'hFF;
    @(posedge clk); #1; req_x[1] = 1'b0;
    @(posedge clk); #1;
    check("t6_in_access_busy", 32'(busy_x[1]), 32'd1);
    rst_x[1] = 1'b0;
    @(negedge clk);
    check("t6_rst_rdata", rdata_x[1], 32'h0);
    check("t6_rst_ack", 32'(ack_x[1]), 32'd0);
    check("t6_rst_busy", 32'(busy_x[1]), 32'd0);
    @(posedge clk); #1; rst_x[1] = 1'b1;
    access(1, 1'b0, 10'h200, '0, '0, rd, lat);
    check("t6_no_commit", rd, 32'h55555555);

    // Randomized traffic on dut0, checked every cycle by the model.
    @(posedge clk); #1;
    for (int c = 0; c < 6000; c++) begin
      req_x[0]   = ($urandom % 3) == 0;
      clr_x[0]   = ($urandom % 500) == 0;
      we_x[0]    = $urandom % 2;
      addr_x[0]  = (($urandom % 4) == 0) ? (10'h3F0 | 10'($urandom % 16)) : 10'($urandom % 16);
      wdata_x[0] = $urandom;
      len_x[0]   = 8'($urandom);
      @(posedge clk); #1;
    end
    req_x[0] = 1'b0; clr_x[0] = 1'b0;
    count_busy(0, n, acks);
    check("rand_drain_timeout", 32'(n >= 3000), 32'd0);
    repeat (4) @(posedge clk);
    cmp_on = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
